// File: rtl/vgm_gbdmg_player.sv
// vgm_gbdmg_player
//   Decodes a VGM command byte stream (header already stripped) and drives the
//   register-write port of the gbdmg sound block. One byte is taken per
//   valid/ready handshake. Game Boy DMG writes (0xB3 aa dd) become
//   out_reg/out_val/out_wr strobes. Waits (0x61/0x62/0x63/0x7n) are timed in
//   44.1 kHz samples of CLK_PER_SAMPLE clocks each.
//
// Ports
//   in_clk     clock
//   in_rst_n   asynchronous active-low reset
//   in_run     1 = play, 0 = pause
//   in_data    VGM stream byte
//   in_valid   in_data valid
//   out_ready  decoder accepts in_data this cycle
//   out_reg    gbdmg register index (aa = address - 0xFF10)
//   out_val    gbdmg register value
//   out_wr     write strobe (gbdmg latches on its rising edge)
//   out_done   end-of-data (0x66) seen, sticky
//   out_err    unsupported opcode seen, sticky
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_FETCH_CMD | waiting for a command byte
// S_FETCH_A0  | waiting for first argument (aa or wait lo)
// S_FETCH_A1  | waiting for second argument (dd or wait hi)
// S_WR_HI     | out_wr high for WR_HOLD cycles
// S_WR_LO     | out_wr low for WR_HOLD cycles
// S_WAIT      | counting down samples; frozen while paused
// S_DONE      | end of data, held until reset
// S_ERR       | unsupported opcode, held until reset

module vgm_gbdmg_player #(
    parameter logic [15:0] CLK_PER_SAMPLE = 16'd95,
    parameter logic [3:0]  WR_HOLD        = 4'd1
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic       in_run,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       out_ready,
    output logic [5:0] out_reg,
    output logic [7:0] out_val,
    output logic       out_wr,
    output logic       out_done,
    output logic       out_err
);

    typedef enum logic [2:0] {
        S_FETCH_CMD = 3'd0,
        S_FETCH_A0  = 3'd1,
        S_FETCH_A1  = 3'd2,
        S_WR_HI     = 3'd3,
        S_WR_LO     = 3'd4,
        S_WAIT      = 3'd5,
        S_DONE      = 3'd6,
        S_ERR       = 3'd7
    } state_t;

    localparam logic [15:0] SUB_RELOAD  = CLK_PER_SAMPLE - 16'd1;
    localparam logic [3:0]  HOLD_RELOAD = WR_HOLD - 4'd1;

    state_t      state_q, state_d;
    logic        is_wait_q, is_wait_d;   // current 3-byte command is 0x61 (else 0xB3)
    logic [7:0]  a0_q, a0_d;
    logic [5:0]  reg_q, reg_d;
    logic [7:0]  val_q, val_d;
    logic [15:0] samp_q, samp_d;
    logic [15:0] sub_q, sub_d;
    logic [3:0]  hold_q, hold_d;

    logic        accept;

    assign accept = in_valid && out_ready;

    // State and datapath registers
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q   <= S_FETCH_CMD;
            is_wait_q <= 1'b0;
            a0_q      <= 8'd0;
            reg_q     <= 6'd0;
            val_q     <= 8'd0;
            samp_q    <= 16'd0;
            sub_q     <= 16'd0;
            hold_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            is_wait_q <= is_wait_d;
            a0_q      <= a0_d;
            reg_q     <= reg_d;
            val_q     <= val_d;
            samp_q    <= samp_d;
            sub_q     <= sub_d;
            hold_q    <= hold_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        is_wait_d = is_wait_q;
        a0_d      = a0_q;
        reg_d     = reg_q;
        val_d     = val_q;
        samp_d    = samp_q;
        sub_d     = sub_q;
        hold_d    = hold_q;

        case (state_q)
            S_FETCH_CMD: begin
                if (accept) begin
                    case (in_data)
                        8'hB3: begin
                            is_wait_d = 1'b0;
                            state_d   = S_FETCH_A0;
                        end
                        8'h61: begin
                            is_wait_d = 1'b1;
                            state_d   = S_FETCH_A0;
                        end
                        8'h62: begin
                            samp_d  = 16'd735;
                            sub_d   = SUB_RELOAD;
                            state_d = S_WAIT;
                        end
                        8'h63: begin
                            samp_d  = 16'd882;
                            sub_d   = SUB_RELOAD;
                            state_d = S_WAIT;
                        end
                        8'h66: begin
                            state_d = S_DONE;
                        end
                        default: begin
                            if (in_data[7:4] == 4'h7) begin
                                // 0x7n waits n+1 samples (1..16)
                                samp_d  = {12'd0, in_data[3:0]} + 16'd1;
                                sub_d   = SUB_RELOAD;
                                state_d = S_WAIT;
                            end else begin
                                state_d = S_ERR;
                            end
                        end
                    endcase
                end
            end

            S_FETCH_A0: begin
                if (accept) begin
                    a0_d    = in_data;
                    state_d = S_FETCH_A1;
                end
            end

            S_FETCH_A1: begin
                if (accept) begin
                    if (is_wait_q) begin
                        if ({in_data, a0_q} == 16'd0) begin
                            state_d = S_FETCH_CMD;
                        end else begin
                            samp_d  = {in_data, a0_q};
                            sub_d   = SUB_RELOAD;
                            state_d = S_WAIT;
                        end
                    end else if (a0_q[7:6] == 2'b00) begin
                        reg_d   = a0_q[5:0];
                        val_d   = in_data;
                        hold_d  = HOLD_RELOAD;
                        state_d = S_WR_HI;
                    end else begin
                        // Address outside the gbdmg window: swallow silently.
                        state_d = S_FETCH_CMD;
                    end
                end
            end

            // Strobe phases ignore in_run so a pause never stretches a write.
            S_WR_HI: begin
                if (hold_q == 4'd0) begin
                    hold_d  = HOLD_RELOAD;
                    state_d = S_WR_LO;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end

            S_WR_LO: begin
                if (hold_q == 4'd0) begin
                    state_d = S_FETCH_CMD;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end

            S_WAIT: begin
                if (in_run) begin
                    if (sub_q == 16'd0) begin
                        sub_d  = SUB_RELOAD;
                        samp_d = samp_q - 16'd1;
                        if (samp_q == 16'd1) begin
                            state_d = S_FETCH_CMD;
                        end
                    end else begin
                        sub_d = sub_q - 16'd1;
                    end
                end
            end

            S_DONE: state_d = S_DONE;
            S_ERR:  state_d = S_ERR;

            default: state_d = S_FETCH_CMD;
        endcase
    end

    // Outputs. out_ready is also gated by reset so every output reads 0
    // while reset is held, even with in_run high.
    always_comb begin
        out_ready = in_rst_n && in_run &&
                    ((state_q == S_FETCH_CMD) ||
                     (state_q == S_FETCH_A0)  ||
                     (state_q == S_FETCH_A1));
        out_wr    = (state_q == S_WR_HI);
        out_done  = (state_q == S_DONE);
        out_err   = (state_q == S_ERR);
        out_reg   = reg_q;
        out_val   = val_q;
    end

endmodule
